// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, widths and timing helper for the systolic feeder
// Purpose: element/accumulator widths, feeder state encoding and the RUN-length helper.
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Cycles from the first operand at index 0 until the last pair reaches PE[n-1][n-1].
  function automatic int runCycles(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/skew_stream.sv
// rtl/skew_stream.sv - one diagonally skewed operand stream (load / shift / clear)
// Purpose: LEN-deep byte buffer. On load, the N input elements land at positions
//          OFFSET..OFFSET+N-1 and every other slot is zero; on shift, each slot takes
//          its upper neighbour and the top slot takes zero.
// Ports:
//   i_clk, i_arst_n      clock, asynchronous active-low reset
//   i_load, i_shift      parallel load of i_vec / shift toward index 0
//   i_clear              zero the buffer (has priority over load and shift)
//   i_vec                N elements, i_vec[j] goes to slot j+OFFSET
//   o_buf                buffer contents, o_buf[0] is the element presented to the array
module skew_stream
  import systolic_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int OFFSET = 0,
  localparam int LEN    = 2 * N - 1
) (
  input  logic                          i_clk,
  input  logic                          i_arst_n,
  input  logic                          i_load,
  input  logic                          i_shift,
  input  logic                          i_clear,
  input  logic [N-1:0][DATA_W-1:0]      i_vec,
  output logic [LEN-1:0][DATA_W-1:0]    o_buf
);

  logic [LEN-1:0][DATA_W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (i_clear) begin
      data_d = '0;
    end else if (i_load) begin
      // Zero-extend then move the N elements up to their diagonal offset.
      data_d = (LEN * DATA_W)'(i_vec) << (OFFSET * DATA_W);
    end else if (i_shift) begin
      data_d = data_q >> DATA_W;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) data_q <= '0;
    else           data_q <= data_d;
  end

  assign o_buf = data_q;

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - transmit-side sequencer feeding skewed A/B streams to an N x N systolic array
// Purpose: accepts an A/B matrix pair on i_valid & o_ready, loads N row and N column skew
//          streams, shifts them for 3N-2 RUN cycles with o_doProcess high, then pulses o_done.
//          i_abort during RUN returns to IDLE with cleared buffers and no o_done.
// Optional: define SYSTOLIC_FEEDER_JOBCNT_EN to add o_jobCount (completed-job counter).
// Ports:
//   i_clk, i_arst_n      clock, asynchronous active-low reset
//   i_valid / o_ready    job handshake; i_a[r][k] and i_b[k][c] are the operand matrices
//   i_abort              cancel a running job
//   o_row[r][0], o_col[c][0]  current row-r / column-c operands for the array
//   o_doProcess          array process enable
//   o_done               one-cycle pulse when the result matrix is final
//   o_jobCount           (optional) number of completed jobs, wraps at 2^32
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter  int N   = 4,
  localparam int LEN = 2 * N - 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst_n,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]      i_a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]      i_b,
  input  logic                                 i_abort,
  output logic [N-1:0][LEN-1:0][DATA_W-1:0]    o_row,
  output logic [N-1:0][LEN-1:0][DATA_W-1:0]    o_col,
  output logic                                 o_doProcess,
  output logic                                 o_done
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
  ,
  output logic [31:0]                          o_jobCount
`endif
);

  localparam int CNT_W = $clog2(3 * N - 1);
  localparam int LAST  = runCycles(N) - 1;

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ready_d, ready_q;
  logic             do_process_d, do_process_q;
  logic             done_d, done_q;
  logic             accept, shift, clear;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort outranks the final-cycle move to DONE.
        if (i_abort) begin
          clear   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          shift = 1'b1;
          if (cnt_q == CNT_W'(LAST)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        clear   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of the next-state decode.
    ready_d      = (state_d == IDLE);
    do_process_d = (state_d == RUN);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      do_process_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      do_process_q <= do_process_d;
      done_q       <= done_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_doProcess = do_process_q;
  assign o_done      = done_q;

  // Column streams consume B column-wise; gather column c as a vector indexed by k.
  logic [N-1:0][N-1:0][DATA_W-1:0] b_cols;

  always_comb begin
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < N; k++) begin
        b_cols[c][k] = i_b[k][c];
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    skew_stream #(.N(N), .OFFSET(r)) u_row (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_load   (accept),
      .i_shift  (shift),
      .i_clear  (clear),
      .i_vec    (i_a[r]),
      .o_buf    (o_row[r])
    );
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    skew_stream #(.N(N), .OFFSET(c)) u_col (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_load   (accept),
      .i_shift  (shift),
      .i_clear  (clear),
      .i_vec    (b_cols[c]),
      .o_buf    (o_col[c])
    );
  end

`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
  logic [31:0] jobcnt_d, jobcnt_q;

  always_comb begin
    jobcnt_d = jobcnt_q + 32'(state_q == DONE);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) jobcnt_q <= '0;
    else           jobcnt_q <= jobcnt_d;
  end

  assign o_jobCount = jobcnt_q;
`endif

endmodule
